// File: rtl/lc4_wb_regfile.sv
// lc4_wb_regfile: LC4 writeback register file with bypassed reads, NZP register and retire counter
module lc4_wb_regfile #(
  parameter int N  = 16,
  parameter int R  = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gwe,
  input  logic          i_wb_valid,
  input  logic [R-1:0]  i_wb_rd_sel,
  input  logic          i_wb_rd_we,
  input  logic [N-1:0]  i_wb_data,
  input  logic          i_wb_nzp_we,
  input  logic [R-1:0]  i_rs_sel,
  input  logic [R-1:0]  i_rt_sel,
  output logic [N-1:0]  o_rs_data,
  output logic [N-1:0]  o_rt_data,
  output logic [2:0]    o_nzp,
  output logic [2:0]    o_nzp_next,
  output logic [CW-1:0] o_retired
);
  logic [N-1:0] regs [2**R];
  logic wr, nw, ret;
  assign ret = gwe & i_wb_valid;
  assign wr  = ret & i_wb_rd_we;
  assign nw  = ret & i_wb_nzp_we;
  // Reads forward the committing result so D sees W's write in the same cycle
  always_comb begin
    o_rs_data  = (wr && i_rs_sel == i_wb_rd_sel) ? i_wb_data : regs[i_rs_sel];
    o_rt_data  = (wr && i_rt_sel == i_wb_rd_sel) ? i_wb_data : regs[i_rt_sel];
    o_nzp_next = i_wb_data[N-1] ? 3'b100 : (i_wb_data == '0 ? 3'b010 : 3'b001);
  end
  // Commit register write, NZP and retire count on the edge; async reset clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**R; i++) regs[i] <= '0;
      o_nzp     <= 3'b000;
      o_retired <= '0;
    end else begin
      if (wr) regs[i_wb_rd_sel] <= i_wb_data;
      if (nw) o_nzp <= o_nzp_next;
      if (ret) o_retired <= o_retired + 1'b1;
    end
  end
endmodule
